// File: rtl/instr_mem_pipe.sv
// Instruction memory with a one-entry registered fetch response, valid/ready
// handshakes on both sides, and a byte-enabled loader write port.
module instr_mem_pipe #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_instr,
  output logic [31:0] rsp_addr,
  output logic        rsp_fault,
  input  logic        rsp_ready,
  input  logic        flush,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  input  logic [3:0]  ld_be,
  output logic [31:0] fetch_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Storage starts out filled with NOPs; reset never touches it.
  logic [31:0] r_mem [DEPTH] = '{default: NOP_INSTR};

  logic        r_rsp_valid;
  logic [31:0] r_rsp_instr;
  logic [31:0] r_rsp_addr;
  logic        r_rsp_fault;
  logic [31:0] r_fetch_count;

  logic [AW-1:0] w_req_idx;
  logic [AW-1:0] w_ld_idx;
  logic          w_req_fault;
  logic          w_ld_in_range;
  logic          w_accept;
  logic [31:0]   w_rd_data;

  assign w_req_idx     = req_addr[AW+1:2];
  assign w_ld_idx      = ld_addr[AW+1:2];
  assign w_req_fault   = (req_addr[1:0] != 2'b00) || ((req_addr >> (AW + 2)) != 32'd0);
  assign w_ld_in_range = ((ld_addr >> (AW + 2)) == 32'd0);

  // Loader owns the array in any cycle it is active, so reads never race writes.
  assign req_ready = !rst && !flush && !ld_en && (!r_rsp_valid || rsp_ready);
  assign w_accept  = req_valid && req_ready;
  assign w_rd_data = w_req_fault ? NOP_INSTR : r_mem[w_req_idx];

  always_ff @(posedge clk) begin
    if (!rst && ld_en && w_ld_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (ld_be[b]) r_mem[w_ld_idx][8*b +: 8] <= ld_data[8*b +: 8];
      end
    end
  end

  // Response register: load on accept, drop on flush or consume, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_instr   <= NOP_INSTR;
      r_rsp_addr    <= 32'd0;
      r_rsp_fault   <= 1'b0;
      r_fetch_count <= 32'd0;
    end else if (w_accept) begin
      r_rsp_valid   <= 1'b1;
      r_rsp_instr   <= w_rd_data;
      r_rsp_addr    <= req_addr;
      r_rsp_fault   <= w_req_fault;
      r_fetch_count <= r_fetch_count + 32'd1;
    end else if (flush || (r_rsp_valid && rsp_ready)) begin
      r_rsp_valid   <= 1'b0;
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_instr   = r_rsp_instr;
  assign rsp_addr    = r_rsp_addr;
  assign rsp_fault   = r_rsp_fault;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Directed testbench for instr_mem_pipe (DEPTH=256) with hand-computed expectations.
module tb_instr_mem_pipe;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic        rsp_fault;
  logic        rsp_ready;
  logic        flush;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic [3:0]  ld_be;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  instr_mem_pipe #(.DEPTH(256), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_instr(rsp_instr), .rsp_addr(rsp_addr),
    .rsp_fault(rsp_fault), .rsp_ready(rsp_ready), .flush(flush),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_be(ld_be),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    ld_en = 1'b1; ld_addr = a; ld_data = d; ld_be = be;
    cycle();
    ld_en = 1'b0; ld_be = 4'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_addr = 32'd0; rsp_ready = 1'b1;
    flush = 1'b0; ld_en = 1'b0; ld_addr = 32'd0; ld_data = 32'd0; ld_be = 4'h0;
    cycle();
    cycle();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %0b exp 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b exp 0", rsp_valid); end
    checks++; if (rsp_instr !== NOP) begin errors++; $display("FAIL reset_rsp_instr got %h exp %h", rsp_instr, NOP); end
    checks++; if (rsp_addr !== 32'd0) begin errors++; $display("FAIL reset_rsp_addr got %h exp 0", rsp_addr); end
    checks++; if (rsp_fault !== 1'b0) begin errors++; $display("FAIL reset_rsp_fault got %0b exp 0", rsp_fault); end
    checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_fetch_count got %0d exp 0", fetch_count); end
    rst = 1'b0; req_valid = 1'b0;
    cycle();
  endtask

  task automatic test_load_fetch();
    req_valid = 1'b1; req_addr = 32'd0; rsp_ready = 1'b1;
    ld_en = 1'b1; ld_addr = 32'd0; ld_data = 32'h0050_0093; ld_be = 4'hF;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL ld_blocks_ready got %0b exp 0", req_ready); end
    cycle();
    ld_en = 1'b0; ld_be = 4'h0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %0b exp 1", req_ready); end
    cycle();
    req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL lf_valid got %0b exp 1", rsp_valid); end
    checks++; if (rsp_instr !== 32'h0050_0093) begin errors++; $display("FAIL lf_instr got %h exp 00500093", rsp_instr); end
    checks++; if (rsp_addr !== 32'd0) begin errors++; $display("FAIL lf_addr got %h exp 0", rsp_addr); end
    checks++; if (rsp_fault !== 1'b0) begin errors++; $display("FAIL lf_fault got %0b exp 0", rsp_fault); end
    checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL lf_count got %0d exp 1", fetch_count); end
    cycle();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL consume_valid got %0b exp 0", rsp_valid); end
    checks++; if (rsp_instr !== 32'h0050_0093) begin errors++; $display("FAIL consume_instr_kept got %h exp 00500093", rsp_instr); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_instr [3];
    load(32'd4, 32'h1111_1111, 4'hF);
    load(32'd8, 32'h2222_2222, 4'hF);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    exp_instr[0] = 32'h0050_0093; exp_instr[1] = 32'h1111_1111; exp_instr[2] = 32'h2222_2222;
    rsp_ready = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr = 32'(4 * i);
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %0b exp 1", i, req_ready); end
      cycle();
      checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 32'(4 * i) || rsp_instr !== exp_instr[i])
        begin errors++; $display("FAIL b2b_rsp[%0d] got v=%0b a=%h i=%h exp v=1 a=%h i=%h", i, rsp_valid, rsp_addr, rsp_instr, 32'(4 * i), exp_instr[i]); end
    end
    req_valid = 1'b0;
    checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL b2b_count got %0d exp 3", fetch_count); end
    cycle();
  endtask

  task automatic test_backpressure();
    req_valid = 1'b1; req_addr = 32'd4; rsp_ready = 1'b0;
    cycle();
    req_addr = 32'd8;
    for (int i = 0; i < 3; i++) begin
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %0b exp 0", i, req_ready); end
      checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 32'd4 || rsp_instr !== 32'h1111_1111 || rsp_fault !== 1'b0)
        begin errors++; $display("FAIL bp_hold[%0d] got v=%0b a=%h i=%h f=%0b exp v=1 a=4 i=11111111 f=0", i, rsp_valid, rsp_addr, rsp_instr, rsp_fault); end
      cycle();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0b exp 1", req_ready); end
    cycle();
    req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 32'd8 || rsp_instr !== 32'h2222_2222)
      begin errors++; $display("FAIL bp_next got v=%0b a=%h i=%h exp v=1 a=8 i=22222222", rsp_valid, rsp_addr, rsp_instr); end
    checks++; if (fetch_count !== 32'd5) begin errors++; $display("FAIL bp_count got %0d exp 5", fetch_count); end
    cycle();
  endtask

  task automatic test_fault();
    logic [31:0] addrs [4];
    logic [31:0] instrs [4];
    logic        faults [4];
    addrs[0] = 32'h2;   instrs[0] = NOP;           faults[0] = 1'b1;
    addrs[1] = 32'h400; instrs[1] = NOP;           faults[1] = 1'b1;
    addrs[2] = 32'h3FC; instrs[2] = NOP;           faults[2] = 1'b0;
    addrs[3] = 32'h0;   instrs[3] = 32'h0050_0093; faults[3] = 1'b0;
    rsp_ready = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = addrs[i];
      cycle();
      checks++; if (rsp_valid !== 1'b1 || rsp_addr !== addrs[i] || rsp_instr !== instrs[i] || rsp_fault !== faults[i])
        begin errors++; $display("FAIL fault_rsp[%0d] got v=%0b a=%h i=%h f=%0b exp v=1 a=%h i=%h f=%0b", i, rsp_valid, rsp_addr, rsp_instr, rsp_fault, addrs[i], instrs[i], faults[i]); end
    end
    req_valid = 1'b0;
    checks++; if (fetch_count !== 32'd9) begin errors++; $display("FAIL fault_count got %0d exp 9", fetch_count); end
    cycle();
  endtask

  task automatic test_byte_enable();
    logic [31:0] addrs [3];
    logic [31:0] instrs [3];
    load(32'h14, 32'hAAAA_BBBB, 4'b0011);
    load(32'h18, 32'hFFFF_FFFF, 4'b0000);
    load(32'h1B, 32'h7766_5544, 4'b1000);
    load(32'h400, 32'hDEAD_BEEF, 4'hF);
    addrs[0] = 32'h14; instrs[0] = 32'h0000_BBBB;
    addrs[1] = 32'h18; instrs[1] = 32'h7700_0013;
    addrs[2] = 32'h0;  instrs[2] = 32'h0050_0093;
    rsp_ready = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr = addrs[i];
      cycle();
      checks++; if (rsp_instr !== instrs[i] || rsp_fault !== 1'b0)
        begin errors++; $display("FAIL be_rsp[%0d] got i=%h f=%0b exp i=%h f=0", i, rsp_instr, rsp_fault, instrs[i]); end
    end
    req_valid = 1'b0;
    checks++; if (fetch_count !== 32'd12) begin errors++; $display("FAIL be_count got %0d exp 12", fetch_count); end
    cycle();
  endtask

  task automatic test_flush_reset();
    req_valid = 1'b1; req_addr = 32'd4; rsp_ready = 1'b0;
    cycle();
    flush = 1'b1; req_addr = 32'd8;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %0b exp 0", req_ready); end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_ready_rr got %0b exp 0", req_ready); end
    rsp_ready = 1'b0;
    cycle();
    flush = 1'b0; req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b exp 0", rsp_valid); end
    checks++; if (fetch_count !== 32'd13) begin errors++; $display("FAIL flush_count got %0d exp 13", fetch_count); end
    req_valid = 1'b1; req_addr = 32'd8;
    cycle();
    checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 32'd8) begin errors++; $display("FAIL mid_held got v=%0b a=%h exp v=1 a=8", rsp_valid, rsp_addr); end
    rst = 1'b1; ld_en = 1'b1; ld_addr = 32'd0; ld_data = 32'hDEAD_BEEF; ld_be = 4'hF;
    cycle();
    rst = 1'b0; ld_en = 1'b0; ld_be = 4'h0; req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || rsp_instr !== NOP || rsp_addr !== 32'd0 || rsp_fault !== 1'b0)
      begin errors++; $display("FAIL rst_rsp got v=%0b i=%h a=%h f=%0b exp v=0 i=%h a=0 f=0", rsp_valid, rsp_instr, rsp_addr, rsp_fault, NOP); end
    checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", fetch_count); end
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'd0;
    cycle();
    checks++; if (rsp_instr !== 32'h0050_0093) begin errors++; $display("FAIL rst_keep_w0 got %h exp 00500093", rsp_instr); end
    req_addr = 32'h14;
    cycle();
    req_valid = 1'b0;
    checks++; if (rsp_instr !== 32'h0000_BBBB) begin errors++; $display("FAIL rst_keep_w5 got %h exp 0000bbbb", rsp_instr); end
    checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL post_rst_count got %0d exp 2", fetch_count); end
    cycle();
  endtask

  initial begin
    test_reset();
    test_load_fetch();
    test_back_to_back();
    test_backpressure();
    test_fault();
    test_byte_enable();
    test_flush_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_mem_pipe.md
INSTR_MEM_PIPE -- requirements
Module: instr_mem_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of instruction words; must be a power of 2, minimum 4.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013, meaning the fill and fault instruction (addi x0,x0,0).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset; synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1, meaning a fetch request is present.
REQ-006 SHALL have port req_addr, input, 32, meaning the fetch byte address.
REQ-007 SHALL have port req_ready, output, 1, meaning a request is accepted this cycle.
REQ-008 SHALL have port rsp_valid, output, 1, meaning the response register holds a valid fetch.
REQ-009 SHALL have port rsp_instr, output, 32, meaning the fetched instruction.
REQ-010 SHALL have port rsp_addr, output, 32, meaning the byte address of the fetch in rsp_instr.
REQ-011 SHALL have port rsp_fault, output, 1, meaning the fetch was misaligned or out of range.
REQ-012 SHALL have port rsp_ready, input, 1, meaning the consumer takes the response this cycle.
REQ-013 SHALL have port flush, input, 1, meaning discard the held response and block acceptance this cycle.
REQ-014 SHALL have port ld_en, input, 1, meaning a loader write is requested this cycle.
REQ-015 SHALL have port ld_addr, input, 32, meaning the loader byte address (word-aligned; bits [1:0] ignored).
REQ-016 SHALL have port ld_data, input, 32, meaning the loader write data.
REQ-017 SHALL have port ld_be, input, 4, meaning the loader byte enables; bit i writes ld_data[8i+7:8i].
REQ-018 SHALL have port fetch_count, output, 32, meaning the number of accepted fetch requests.

Function
REQ-019 SHALL index storage by word, using req_addr[log2(DEPTH)+1:2].
REQ-020 SHALL drive req_ready = !flush && !ld_en && (!rsp_valid || rsp_ready), combinationally.
REQ-021 SHALL define accept as req_valid && req_ready.
REQ-022 On accept, the next cycle SHALL have rsp_valid=1, rsp_addr=req_addr, and rsp_instr equal to the word stored at the time of acceptance; read latency is exactly 1 cycle.
REQ-023 SHALL detect a fault when req_addr[1:0]!=0 or req_addr >= 4*DEPTH; on a faulting accept it SHALL set rsp_fault=1 and rsp_instr=NOP_INSTR, and storage SHALL NOT be read.
REQ-024 While rsp_valid && !rsp_ready && !flush, it SHALL hold rsp_valid, rsp_instr, rsp_addr and rsp_fault stable.
REQ-025 When rsp_valid && rsp_ready hold with no accept in the same cycle, it SHALL clear rsp_valid next cycle; the other rsp_* outputs keep their last values.
REQ-026 When rsp_valid && rsp_ready hold with an accept in the same cycle, it SHALL load the new response back-to-back, sustaining 1 fetch/cycle.
REQ-027 When flush=1, it SHALL clear rsp_valid next cycle regardless of rsp_ready, and SHALL accept no request that cycle.
REQ-028 When ld_en=1, it SHALL write the enabled bytes of word ld_addr[log2(DEPTH)+1:2] at the clock edge.
  - Out-of-range ld_addr (>= 4*DEPTH) SHALL be dropped silently.
  - ld_be=0 SHALL write nothing.
REQ-029 Loader writes SHALL have priority over fetch; with ld_en=1, req_ready=0, so there is no same-cycle read/write hazard.
REQ-030 A fetch accepted in the cycle after a write SHALL return the newly written data.
REQ-031 SHALL increment fetch_count by 1 per accept, including faulting accepts, and SHALL wrap from 32'hFFFFFFFF to 0.
REQ-032 SHALL initialise every storage word to NOP_INSTR at time zero.

Reset
REQ-033 When rst=1 at a clock edge, it SHALL set rsp_valid=0, rsp_instr=NOP_INSTR, rsp_addr=0, rsp_fault=0 and fetch_count=0.
REQ-034 Reset SHALL NOT alter storage contents.
REQ-035 While rst=1, it SHALL drive req_ready=0 and SHALL perform no loader writes.
REQ-036 Reset asserted mid-transaction SHALL discard the held response with no partial output.

Verification
REQ-037 Load 0x00500093 at ld_addr 0 with ld_be=4'hF; next cycle fetch addr 0 with rsp_ready=1 -> one cycle later rsp_valid=1, rsp_instr=0x00500093, rsp_addr=0, rsp_fault=0, fetch_count=1.
REQ-038 Fetch addrs 0,4,8 on consecutive cycles with rsp_ready=1 -> responses in consecutive cycles, req_ready stays 1, fetch_count=3.
REQ-039 Hold rsp_ready=0 for 3 cycles with a response held -> req_ready=0 and rsp_* stable for 3 cycles; on rsp_ready=1 the response is consumed and the next request is accepted the same cycle.
REQ-040 Fetch addr 0x2 and fetch addr 0x400 (DEPTH=256) -> rsp_fault=1 and rsp_instr=0x00000013 for each; fetch_count increments for both.
REQ-041 Write ld_be=4'b0011, ld_data=0xAAAA_BBBB to word 5 (prior contents 0x00000013) -> fetch of 0x14 returns 0x0000BBBB.
REQ-042 Assert flush with a response held and req_valid=1, then assert rst mid-stream -> rsp_valid=0 next cycle with no accept; after reset fetch_count=0 and storage is unchanged.
